// File: rtl/spi_ram_param_if.sv
// Serial frame port of spi_ram_param: slave select, data in/out and the abort flag.
interface spi_ram_param_if;
    logic ss_n;
    logic mosi;
    logic miso;
    logic frame_abort;

    modport master (output ss_n, output mosi, input miso, input frame_abort);
    modport slave  (input ss_n, input mosi, output miso, output frame_abort);
endinterface

// File: rtl/spi_ram_param.sv
// Serial-framed RAM: 2-bit command + DATA_WIDTH payload per frame, reads shifted out MSB first.
// Optional macro SPI_RAM_AUTOINC_EN: post-increment wr_addr after writes and rd_addr after loads.
module spi_ram_param #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic            clk,
    input  logic            rst,
    spi_ram_param_if.slave  bus
);
    localparam int LP_FRAME = DATA_WIDTH + 2;
    localparam int LP_CNT_W = $clog2(LP_FRAME + 1);
    localparam logic [LP_CNT_W-1:0]   LP_FULL       = LP_CNT_W'(LP_FRAME);
    localparam logic [LP_CNT_W-1:0]   LP_SHIFT_LAST = LP_CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH      = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, RECV, LOAD, SHIFT, DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [LP_CNT_W-1:0]     r_cnt;
    logic [LP_FRAME-1:0]     r_sr;
    logic [DATA_WIDTH-1:0]   r_tx;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic                    r_abort;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic [1:0]              w_cmd;
    logic [DATA_WIDTH-1:0]   w_payload;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_addr_ok;
    logic                    w_exec;
    logic                    w_mem_we;
    logic                    w_abort_set;

    assign w_cmd     = r_sr[LP_FRAME-1 -: 2];
    assign w_payload = r_sr[DATA_WIDTH-1:0];
    assign w_addr    = w_payload[ADDR_WIDTH-1:0];
    assign w_addr_ok = ({1'b0, w_addr} < LP_DEPTH);
    // Command executes one edge after the final bit, only if the frame is still selected.
    assign w_exec    = (r_state == RECV) && !bus.ss_n && (r_cnt == LP_FULL);
    assign w_mem_we  = w_exec && !rst && (w_cmd == 2'b01);

`ifdef SPI_RAM_AUTOINC_EN
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LP_LAST) ? '0 : a + 1'b1;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.ss_n) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = RECV;
                RECV:    if (r_cnt == LP_FULL) w_next = (w_cmd == 2'b11) ? LOAD : DONE;
                LOAD:    w_next = SHIFT;
                SHIFT:   if (r_cnt == LP_SHIFT_LAST) w_next = DONE;
                DONE:    w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.miso        = (r_state == SHIFT) ? r_tx[DATA_WIDTH-1] : 1'b0;
        bus.frame_abort = r_abort;
        w_abort_set     = bus.ss_n && (r_state == RECV || r_state == LOAD || r_state == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_abort <= w_abort_set;
            // One counter serves both the receive bit count and the shift-out count.
            if (w_next == RECV)
                r_cnt <= (r_state == RECV) ? r_cnt + 1'b1 : LP_CNT_W'(1);
            else if (w_next == SHIFT)
                r_cnt <= (r_state == SHIFT) ? r_cnt + 1'b1 : '0;
            else
                r_cnt <= '0;

            if (w_exec) begin
                case (w_cmd)
                    2'b00:   if (w_addr_ok) r_wr_addr <= w_addr;
                    2'b10:   if (w_addr_ok) r_rd_addr <= w_addr;
`ifdef SPI_RAM_AUTOINC_EN
                    2'b01:   r_wr_addr <= f_next_addr(r_wr_addr);
`endif
                    default: ;
                endcase
            end
`ifdef SPI_RAM_AUTOINC_EN
            if (r_state == LOAD && !bus.ss_n) r_rd_addr <= f_next_addr(r_rd_addr);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE || (r_state == RECV && r_cnt != LP_FULL))
            r_sr <= {r_sr[LP_FRAME-2:0], bus.mosi};
        if (r_state == LOAD)
            r_tx <= r_mem[r_rd_addr];
        else if (r_state == SHIFT)
            r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
        if (w_mem_we)
            r_mem[r_wr_addr] <= w_payload;
    end
endmodule
